// File: rtl/seg7_reader.sv
// Two-digit 7-segment readback block.
// The block synchronizes the active-low segment lines of both digits and
// waits until a pattern has been stable for STABLE_CYCLES samples. It then
// decodes any newly accepted pattern to BCD digits plus a binary value.
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] seg_h,
  input  logic [6:0] seg_l,
  output logic       valid,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] value,
  output logic       blank,
  output logic       err
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned PAT_W = 2 * SEG_W;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned VAL_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [PAT_W-1:0] PAT_BLANK = {SEG_BLANK, SEG_BLANK};
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    SETTLE  = 1'b0,
    PUBLISH = 1'b1
  } state_t;

  // Decoded form of one segment code.
  typedef struct packed {
    logic       is_digit;
    logic       is_blank;
    logic [3:0] digit;
  } dec_t;

  state_t           state;
  state_t           state_nxt;
  logic [PAT_W-1:0] sync1;
  logic [PAT_W-1:0] s;
  logic [PAT_W-1:0] s_prev;
  logic [PAT_W-1:0] pub;
  logic [PAT_W-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic             same_c;
  logic             accept_c;

  dec_t             dec_h_c;
  dec_t             dec_l_c;
  logic             nxt_blank_c;
  logic             nxt_err_c;
  logic [3:0]       nxt_tens_c;
  logic [3:0]       nxt_ones_c;
  logic [VAL_W-1:0] nxt_value_c;

  // Inverse of the digit-to-segment encoder (a = MSB, 0 = lit).
  function automatic dec_t seg_decode(input logic [SEG_W-1:0] code);
    dec_t d;
    d.is_digit = 1'b1;
    d.is_blank = 1'b0;
    d.digit    = 4'd0;
    case (code)
      7'h01:   d.digit = 4'd0;
      7'h4F:   d.digit = 4'd1;
      7'h12:   d.digit = 4'd2;
      7'h06:   d.digit = 4'd3;
      7'h4C:   d.digit = 4'd4;
      7'h24:   d.digit = 4'd5;
      7'h60:   d.digit = 4'd6;
      7'h0F:   d.digit = 4'd7;
      7'h00:   d.digit = 4'd8;
      7'h0C:   d.digit = 4'd9;
      7'h7F: begin
        d.is_digit = 1'b0;
        d.is_blank = 1'b1;
      end
      default: d.is_digit = 1'b0;
    endcase
    return d;
  endfunction

  assign same_c   = (s == s_prev);
  assign accept_c = en && same_c && (cnt == CNT_LAST);

  // Two-flop synchronizer plus previous-sample stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= PAT_BLANK;
      s      <= PAT_BLANK;
      s_prev <= PAT_BLANK;
    end else begin
      sync1  <= {seg_h, seg_l};
      s      <= sync1;
      s_prev <= s;
    end
  end

  // Stability counter: clears on disable or change, saturates at STABLE_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || !same_c) begin
      cnt <= '0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Candidate pattern captured on the accept edge for use during PUBLISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= PAT_BLANK;
    end else if (accept_c) begin
      cand <= s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SETTLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: only an accepted pattern that differs from pub publishes.
  always_comb begin
    state_nxt = state;
    case (state)
      SETTLE:  if (accept_c && (s != pub)) state_nxt = PUBLISH;
      PUBLISH: state_nxt = SETTLE;
      default: state_nxt = SETTLE;
    endcase
  end

  // Decode of the candidate; an undecodable pattern holds the digits and value.
  always_comb begin
    dec_h_c     = seg_decode(cand[PAT_W-1:SEG_W]);
    dec_l_c     = seg_decode(cand[SEG_W-1:0]);
    nxt_blank_c = 1'b0;
    nxt_err_c   = 1'b0;
    nxt_tens_c  = tens;
    nxt_ones_c  = ones;
    nxt_value_c = value;
    if (dec_h_c.is_blank && dec_l_c.is_blank) begin
      nxt_blank_c = 1'b1;
      nxt_tens_c  = 4'd0;
      nxt_ones_c  = 4'd0;
      nxt_value_c = '0;
    end else if (dec_l_c.is_digit && (dec_h_c.is_blank || dec_h_c.is_digit)) begin
      nxt_tens_c  = dec_h_c.is_blank ? 4'd0 : dec_h_c.digit;
      nxt_ones_c  = dec_l_c.digit;
      nxt_value_c = (VAL_W'(nxt_tens_c) << 3) + (VAL_W'(nxt_tens_c) << 1)
                  + VAL_W'(nxt_ones_c);
    end else begin
      nxt_err_c   = 1'b1;
    end
  end

  // Registered outputs and published pattern, loaded on the PUBLISH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tens  <= 4'd0;
      ones  <= 4'd0;
      value <= '0;
      blank <= 1'b1;
      err   <= 1'b0;
      pub   <= PAT_BLANK;
    end else if (state == PUBLISH) begin
      valid <= 1'b1;
      tens  <= nxt_tens_c;
      ones  <= nxt_ones_c;
      value <= nxt_value_c;
      blank <= nxt_blank_c;
      err   <= nxt_err_c;
      pub   <= cand;
    end else begin
      valid <= 1'b0;
    end
  end

endmodule
